bcd_serial_addsub: RTL and testbench



---
 rtl/bcd_serial_addsub.sv | 154 +++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub.sv
// Multi-digit packed-BCD adder/subtractor that processes one decimal digit per clock, LSD first.
// Define BCD_INVALID_CHK_EN to flag operands that contain a digit greater than 9.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                carry_out,
    output logic                invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Handshake: start is sampled only in IDLE; done pulses for one cycle when
    // sum/carry_out take the new result, and busy covers the RUN cycles.
    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    acc;
    logic [W-1:0]    res_next;
    logic [W-1:0]    sum_q;
    logic            sub_q;
    logic            c_q;
    logic            c_next;
    logic            co_q;
    logic            done_q;
    logic            accept;
    logic            last;
    logic [3:0]      a_d;
    logic [3:0]      b_d;
    logic [3:0]      b_eff;
    logic [3:0]      digit;
    logic [4:0]      t;

    assign accept = (state == IDLE) && start;
    assign last   = (cnt == CW'(DIGITS - 1));

    // One decimal digit slice: nine's complement of b in subtract mode, then
    // the classic add-6 correction when the binary sum exceeds 9.
    always_comb begin
        a_d      = a_q[4*cnt +: 4];
        b_d      = b_q[4*cnt +: 4];
        b_eff    = sub_q ? (4'd9 - b_d) : b_d;
        t        = {1'b0, a_d} + {1'b0, b_eff} + {4'b0000, c_q};
        digit    = t[3:0];
        c_next   = 1'b0;
        if (t > 5'd9) begin
            digit  = t[3:0] + 4'd6;
            c_next = 1'b1;
        end
        res_next = acc;
        res_next[4*cnt +: 4] = digit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            sum_q  <= '0;
            sub_q  <= 1'b0;
            c_q    <= 1'b0;
            co_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                sub_q <= sub;
                c_q   <= sub ? 1'b1 : carry_in;
                cnt   <= '0;
                acc   <= '0;
            end else if (state == RUN) begin
                acc <= res_next;
                c_q <= c_next;
                cnt <= last ? '0 : cnt + CW'(1);
                if (last) begin
                    sum_q  <= res_next;
                    co_q   <= c_next;
                    done_q <= 1'b1;
                end
            end
        end
    end

`ifdef BCD_INVALID_CHK_EN
    logic inv_q;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if (accept) begin
            inv_q <= has_bad_digit(a) | has_bad_digit(b);
        end
    end
`endif

    always_comb begin
        busy      = (state == RUN);
        done      = done_q;
        sum       = sum_q;
        carry_out = co_q;
`ifdef BCD_INVALID_CHK_EN
        invalid   = inv_q;
`else
        invalid   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub (DIGITS=4): vector table plus handshake/reset sequences.
module tb_bcd_serial_addsub;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         invalid;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] es;
        logic         eco;
    } vec_t;

    vec_t vecs[11];

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .invalid   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive operands and hold start for one rising edge; returns #1 after that edge.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic sv, input logic cv);
        a        = av;
        b        = bv;
        sub      = sv;
        carry_in = cv;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    // Count edges until done, checking busy on the way; returns the edge count.
    task automatic wait_done(input string name, output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (!done) check({name, "_busy"}, 32'(busy), 32'd1);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sv, input logic cv, input logic [W-1:0] es,
                          input logic eco, input logic chk);
        int lat;
        start_op(av, bv, sv, cv);
        check({name, "_busy_start"}, 32'(busy), 32'd1);
        check({name, "_done_start"}, 32'(done), 32'd0);
        wait_done(name, lat);
        check({name, "_latency"}, 32'(lat), 32'(DIGITS));
        check({name, "_busy_end"}, 32'(busy), 32'd0);
        if (chk) begin
            check({name, "_sum"}, 32'(sum), 32'(es));
            check({name, "_cout"}, 32'(carry_out), 32'(eco));
        end
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        if (chk) check({name, "_sum_hold"}, 32'(sum), 32'(es));
    endtask

    initial begin
        int lat;
        int n_done;

        vecs[0]  = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0};
        vecs[1]  = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[2]  = '{16'h9999, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1};
        vecs[3]  = '{16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b1};
        vecs[4]  = '{16'h1234, 16'h5000, 1'b1, 1'b0, 16'h6234, 1'b0};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0};
        vecs[7]  = '{16'h9999, 16'h9999, 1'b1, 1'b0, 16'h0000, 1'b1};
        vecs[8]  = '{16'h5555, 16'h4445, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[9]  = '{16'h0001, 16'h0002, 1'b1, 1'b0, 16'h9999, 1'b0};
        vecs[10] = '{16'h0100, 16'h0001, 1'b1, 1'b1, 16'h0099, 1'b1};

        rst_n    = 1'b0;
        start    = 1'b0;
        sub      = 1'b0;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(carry_out), 32'd0);
        check("rst_invalid", 32'(invalid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
                   vecs[i].es, vecs[i].eco, 1'b1);
        end

        // start pulsed two cycles into an operation must be ignored
        start_op(16'h1234, 16'h5678, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start_op(16'h1111, 16'h1111, 1'b1, 1'b0);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("ign_latency", 32'(lat), 32'd2);
        check("ign_sum", 32'(sum), 32'h6912);
        check("ign_cout", 32'(carry_out), 32'd0);
        n_done = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("ign_no_second_done", 32'(n_done), 32'd0);
        check("ign_idle", 32'(busy), 32'd0);

        // back-to-back: start accepted in the done cycle
        start_op(16'h0042, 16'h0058, 1'b0, 1'b0);
        wait_done("b2b_first", lat);
        check("b2b_first_sum", 32'(sum), 32'h0100);
        start_op(16'h0500, 16'h0001, 1'b1, 1'b0);
        lat = 1;
        check("b2b_accept_busy", 32'(busy), 32'd1);
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_gap", 32'(lat), 32'(DIGITS + 1));
        check("b2b_second_sum", 32'(sum), 32'h0499);
        check("b2b_second_cout", 32'(carry_out), 32'd1);
        @(posedge clk);
        #1;

        // asynchronous reset two cycles into an operation
        start_op(16'h9999, 16'h0001, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_cout", 32'(carry_out), 32'd0);
        check("arst_invalid", 32'(invalid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_done = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done || busy) n_done++;
        end
        check("arst_no_done", 32'(n_done), 32'd0);
        run_op("post_rst", 16'h2718, 16'h3141, 1'b0, 1'b1, 16'h5860, 1'b0, 1'b1);

        // operand with a non-decimal digit
        start_op(16'h12A4, 16'h0001, 1'b0, 1'b0);
`ifdef BCD_INVALID_CHK_EN
        check("inv_set", 32'(invalid), 32'd1);
`else
        check("inv_tied", 32'(invalid), 32'd0);
`endif
        wait_done("inv", lat);
        check("inv_latency", 32'(lat), 32'(DIGITS));
`ifdef BCD_INVALID_CHK_EN
        check("inv_hold", 32'(invalid), 32'd1);
`else
        check("inv_hold_tied", 32'(invalid), 32'd0);
`endif
        @(posedge clk);
        #1;
        run_op("inv_clear_op", 16'h0007, 16'h0003, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b1);
        check("inv_cleared", 32'(invalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
